seg_scan_driver: RTL
====================

// Module: seg_scan_driver
// PURPOSE
//  Time-multiplexed scan stage for the EGO1 8-digit display, downstream of switch/logic sources.
//  Latches a 32-bit hex word with per-digit enable and decimal-point masks.
//  Decodes each nibble to 7-segment form and drives both 4-digit segment buses plus the 8 digit selects.
//  Scans one digit per group per slot, with anti-ghost blanking between slots.
// PARAMETERS
//  DIV    100000  clocks per scan slot (1 kHz slot rate @100 MHz); legal range DIV >= 2
//  BLANK  100     clocks at slot start with all outputs dark; legal range 0 <= BLANK < DIV
// PORTS
//  clk_pin         in   1   system clock, all logic on rising edge
//  rst_n_pin       in   1   asynchronous, active-low reset
//  data_in         in   32  hex word; nibble 7 [31:28] = leftmost digit, nibble 0 = rightmost
//  dp_in           in   8   decimal point per digit; bit i pairs with nibble i
//  en_in           in   8   digit enable per digit; bit i pairs with nibble i
//  load_in         in   1   1-cycle strobe: capture data_in/dp_in/en_in
//  seg_data_0_pin  out  8   left group segments {dp,g,f,e,d,c,b,a}, active-high
//  seg_data_1_pin  out  8   right group segments, same order
//  seg_cs_pin      out  8   digit selects, active-high; [7:4] left group, [3:0] right group, bit7 leftmost
//  frame_done      out  1   1-cycle pulse at end of slot 3
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0.
//   div_cnt=0, slot=0.
//   shadow {data,dp,en}=0, so the display is dark.
//   pending register and pending_valid cleared.
//  Counters:
//   div_cnt counts 0..DIV-1 and wraps.
//   slot (2 bits) increments when div_cnt==DIV-1; 3 wraps to 0.
//   Frame = 4 slots = 4*DIV clocks.
//  Slot s mapping:
//   left group digit cs[7-s] shows nibble 7-s.
//   right group digit cs[3-s] shows nibble 3-s.
//  Decode table 0-F: 3f 06 5b 4f 66 6d 7d 07 7f 6f 77 7c 39 5e 79 71.
//   Bit7 is forced to dp of that digit.
//  Output timing: outputs registered; the value at cycle t+1 reflects {slot, div_cnt, shadow} at cycle t.
//  Blanking: while div_cnt < BLANK, seg_data_0/1 and seg_cs are 0.
//  Otherwise:
//   cs[7-s] = en[7-s] and cs[3-s] = en[3-s]; all other cs bits are 0.
//   A group's segment bus is 0 when that group's digit is disabled.
//  Load handshake:
//   load_in copies its inputs into pending and sets pending_valid; a later load overwrites pending (last wins).
//   At the frame-end cycle (slot==3 && div_cnt==DIV-1), shadow <= pending if pending_valid; pending_valid cleared.
//   load_in asserted in the frame-end cycle bypasses pending and goes straight to shadow.
//   Shadow never changes mid-frame, so there is no tearing.
//  frame_done: registered; high exactly 1 cycle, on the cycle after the frame-end cycle.
//  Reset mid-frame: immediate dark outputs; pending load discarded; scanning restarts at slot 0.
// TESTING
//  (bench uses DIV=8, BLANK=2)
//  1. Reset release, no load -> seg_cs_pin/seg_data_*=0 for 3 full frames; frame_done every 32 clocks.
//  2. load data=32'h0123_89AB, dp=0, en=FF; wait for frame boundary ->
//     slot0 shows cs=8'h88, seg0=3f, seg1=7f;
//     slot3 shows cs=8'h11, seg0=4f, seg1=7c.
//  3. Each slot: outputs 0 for the first 2 cycles after the slot boundary, then stable for 6 cycles.
//     Never two cs bits in the same group high.
//  4. en=8'h0F, dp=8'h01, data=32'hFFFF_FFFF ->
//     seg0 and cs[7:4] stay 0;
//     right digit 0 (slot 3) shows seg1=8'hF1.
//  5. load mid-slot1 then another load mid-slot2 -> display unchanged until frame end, then shows the 2nd value.
//     Load in the frame-end cycle -> applied at that boundary.
//  6. Assert rst_n_pin low during slot 2 with a pending load -> outputs 0 asynchronously.
//     After release, still dark (pending dropped); slot restarts at 0.

Source files
------------

// File: rtl/seg_scan_if.sv
// Bus between the display source and the 8-digit scan driver: load side in, scan outputs back.
interface seg_scan_if;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic [7:0]  en_in;
  logic        load_in;
  logic [7:0]  seg_data_0_pin;
  logic [7:0]  seg_data_1_pin;
  logic [7:0]  seg_cs_pin;
  logic        frame_done;

  modport master (
    output data_in, dp_in, en_in, load_in,
    input  seg_data_0_pin, seg_data_1_pin, seg_cs_pin, frame_done
  );

  modport slave (
    input  data_in, dp_in, en_in, load_in,
    output seg_data_0_pin, seg_data_1_pin, seg_cs_pin, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 2x4-digit 7-segment scanner with frame-synchronous word update
// and per-slot anti-ghost blanking.
module seg_scan_driver #(
  parameter int unsigned DIV   = 100000,
  parameter int unsigned BLANK = 100
) (
  input  logic     clk_pin,
  input  logic     rst_n_pin,
  seg_scan_if.slave bus
);
  localparam int unsigned     CW       = $clog2(DIV);
  localparam logic [CW-1:0]   DIV_LAST = CW'(DIV - 1);
  localparam logic [CW:0]     BLANK_C  = (CW+1)'(BLANK);

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  en;
  } disp_t;

  logic [CW-1:0] div_q, div_d;
  logic [1:0]    slot_q, slot_d;
  disp_t         shadow_q, shadow_d;
  disp_t         pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic [7:0]    cs_q, cs_d;
  logic [7:0]    seg0_q, seg0_d;
  logic [7:0]    seg1_q, seg1_d;
  logic          fd_q, fd_d;

  logic          slot_end, frame_end, blank;
  logic [2:0]    lsel, rsel;
  disp_t         in_w;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h3f;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5b;  4'h3: seg7 = 7'h4f;
      4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6d;  4'h6: seg7 = 7'h7d;  4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7f;  4'h9: seg7 = 7'h6f;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7c;
      4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5e;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    in_w      = '{data: bus.data_in, dp: bus.dp_in, en: bus.en_in};
    slot_end  = (div_q == DIV_LAST);
    frame_end = slot_end && (slot_q == 2'd3);
    blank     = ({1'b0, div_q} < BLANK_C);
    div_d     = slot_end ? '0 : div_q + 1'b1;
    slot_d    = slot_end ? slot_q + 2'd1 : slot_q;

    // A load coinciding with the frame boundary wins over anything pending.
    shadow_d = shadow_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (frame_end) begin
      if (bus.load_in)   shadow_d = in_w;
      else if (pend_v_q) shadow_d = pend_q;
      pend_v_d = 1'b0;
    end else if (bus.load_in) begin
      pend_d   = in_w;
      pend_v_d = 1'b1;
    end

    // Slot s drives digit 7-s on the left group and 3-s on the right group.
    lsel   = {1'b1, ~slot_q};
    rsel   = {1'b0, ~slot_q};
    cs_d   = '0;
    seg0_d = '0;
    seg1_d = '0;
    if (!blank) begin
      cs_d[lsel] = shadow_q.en[lsel];
      cs_d[rsel] = shadow_q.en[rsel];
      if (shadow_q.en[lsel])
        seg0_d = {shadow_q.dp[lsel], seg7(shadow_q.data[{lsel, 2'b00} +: 4])};
      if (shadow_q.en[rsel])
        seg1_d = {shadow_q.dp[rsel], seg7(shadow_q.data[{rsel, 2'b00} +: 4])};
    end
    fd_d = frame_end;
  end

  always_ff @(posedge clk_pin or negedge rst_n_pin) begin
    if (!rst_n_pin) begin
      div_q    <= '0;
      slot_q   <= '0;
      shadow_q <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      cs_q     <= '0;
      seg0_q   <= '0;
      seg1_q   <= '0;
      fd_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      cs_q     <= cs_d;
      seg0_q   <= seg0_d;
      seg1_q   <= seg1_d;
      fd_q     <= fd_d;
    end
  end

  assign bus.seg_cs_pin     = cs_q;
  assign bus.seg_data_0_pin = seg0_q;
  assign bus.seg_data_1_pin = seg1_q;
  assign bus.frame_done     = fd_q;
endmodule
